input_queue_sequencer: RTL and testbench
========================================

Name: input_queue_sequencer

Overview:
- Controller for the input-layer pixel queue: clears the queue, streams exactly INPUT_LAYER_NODES binary pixels into it, waits for load completion, then drains the active-pixel indices onto a valid/ready index stream.
- Sits between the image source and the first-layer weight/accumulate datapath; one image per start pulse.

Parameters:
- INPUT_LAYER_NODES, 784, pixels per image; tested at 10.
- INDEX_WIDTH, 10, width of queue index and count fields; must satisfy 2^INDEX_WIDTH >= INPUT_LAYER_NODES.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins an image; ignored unless IDLE.
- abort  in  1  synchronous; returns to IDLE from any state.
- pixelValid  in  1  upstream pixel present.
- pixelIn  in  1  pixel value.
- pixelReady  out  1  high only in LOAD.
- queueReset  out  1  active-high clear to queue.
- queuePixel  out  1  pixel presented to queue.
- queueDequeue  out  1  one-cycle dequeue pulse.
- queueIndex  in  INDEX_WIDTH  head index from queue.
- queueEmpty  in  1  queue has no indices.
- queueFinished  in  1  queue has captured all pixels.
- indexValid  out  1  indexOut is valid.
- indexOut  out  INDEX_WIDTH  active pixel index.
- indexReady  in  1  downstream accepts the index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the image is fully drained.
- underrun  out  1  one-cycle pulse on a pixel gap during LOAD.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all outputs 0, loadCount 0.
- States: IDLE, CLEAR, LOAD, WAIT_FIN, DRAIN, GAP, DONE.
- IDLE: on start, go to CLEAR.
- CLEAR: queueReset=1 for exactly one cycle, then go to LOAD.
- LOAD:
  - pixelReady=1.
  - The queue samples queuePixel on every clock, so pixels must be contiguous.
  - Each cycle with pixelValid=1: queuePixel=pixelIn, loadCount increments.
  - After the INPUT_LAYER_NODES-th accepted pixel, go to WAIT_FIN.
  - First-cycle pixelValid=0 is allowed: stay in LOAD, count 0, queueReset reasserted each such cycle.
  - pixelValid=0 after at least one pixel: underrun pulse, queueReset pulse, go to IDLE.
- WAIT_FIN: hold until queueFinished=1, then go to DRAIN.
- DRAIN:
  - If queueEmpty=1, go to DONE.
  - Otherwise indexValid=1 and indexOut=queueIndex, held stable until indexReady.
  - On indexValid&&indexReady: queueDequeue=1 in the same cycle (combinational), then go to GAP.
- GAP: one bubble cycle for the queue head to update; indexValid=0; return to DRAIN. Peak rate is one index per 2 cycles.
- DONE: done=1 for one cycle, then go to IDLE. queueEmpty on the first DRAIN cycle means a zero-index image; done still pulses.
- Simultaneous events:
  - start with abort: abort wins.
  - abort in any state: the next cycle is IDLE, with one queueReset pulse if the state was not IDLE.
  - start while busy: ignored, no queuing.
- loadCount is INDEX_WIDTH+1 bits and never wraps; it is compared against INPUT_LAYER_NODES-1 at acceptance.

Optional Feature:
- Macro: INPUT_SEQ_COUNT_EN.
- Defined:
  - Adds output activeCount [INDEX_WIDTH:0].
  - Cleared in CLEAR; increments on each accepted index; holds after DONE until the next start.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE, 3 bits), INPUT_LAYER_NODES and INDEX_WIDTH defaults. These live alongside the existing global variables include.
- No sub-module needed. The load counter is an inline register; the FSM is a single always block plus a combinational output decode.

Test Plan (INPUT_LAYER_NODES=10, queue instance attached):
- Reset, start, pixels 0,0,1,0,1,1,0,1,0,1 contiguous, indexReady=1 -> indices 2,4,5,7,9, each with one GAP cycle between; done pulse; busy falls the cycle after done.
- Second image 1,1,0,1,1,0,1,1,0,0 with indexReady toggled 1/0 -> indices 0,1,3,4,6,7; indexOut held stable while indexReady=0; no duplicate or lost indices.
- All-zero image -> no indexValid; done pulses exactly once, the cycle after queueEmpty is seen in DRAIN.
- pixelValid drops after the 4th pixel -> underrun pulse; queueReset pulse; IDLE; a subsequent start completes normally.
- abort during DRAIN after 2 indices -> IDLE next cycle, queueReset pulse, no done pulse. Separately, reset low mid-LOAD -> all outputs 0 immediately.
- With INPUT_SEQ_COUNT_EN defined on the first scenario -> activeCount=5 after done.

Source files
------------

// File: rtl/input_queue_sequencer_pkg.sv
// Shared definitions for the input-layer pixel queue sequencer: the
// state encoding and the default image geometry.
package input_queue_sequencer_pkg;

  localparam int INPUT_LAYER_NODES_DEF = 784;
  localparam int INDEX_WIDTH_DEF       = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_WAIT_FIN = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/input_queue_sequencer.sv
// Input-layer pixel queue sequencer: clears the queue, streams one image of
// binary pixels into it, waits for the queue to finish capturing, then drains
// the active-pixel indices onto a valid/ready stream.
// Optional build macro INPUT_SEQ_COUNT_EN adds the activeCount output, a
// count of indices accepted downstream for the current image.
module input_queue_sequencer
  import input_queue_sequencer_pkg::*;
#(
  parameter int INPUT_LAYER_NODES = INPUT_LAYER_NODES_DEF,
  parameter int INDEX_WIDTH       = INDEX_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   pixelValid,
  input  logic                   pixelIn,
  output logic                   pixelReady,
  output logic                   queueReset,
  output logic                   queuePixel,
  output logic                   queueDequeue,
  input  logic [INDEX_WIDTH-1:0] queueIndex,
  input  logic                   queueEmpty,
  input  logic                   queueFinished,
  output logic                   indexValid,
  output logic [INDEX_WIDTH-1:0] indexOut,
  input  logic                   indexReady,
  output logic                   busy,
  output logic                   done,
`ifdef INPUT_SEQ_COUNT_EN
  output logic [INDEX_WIDTH:0]   activeCount,
`endif
  output logic                   underrun
);

  // Count value at which the pixel being accepted is the last of the image.
  localparam logic [INDEX_WIDTH:0] LAST_PIXEL = (INDEX_WIDTH+1)'(INPUT_LAYER_NODES - 1);

  seq_state_e             state_r;
  seq_state_e             next_state_s;
  logic [INDEX_WIDTH:0]   load_count_r;
  logic                   load_inc_s;
  logic                   accept_s;

  assign busy = (state_r != ST_IDLE);

  // Next-state and output decode; abort overrides everything and only
  // clears the queue when an image was in progress.
  always_comb begin
    next_state_s = state_r;
    pixelReady   = 1'b0;
    queueReset   = 1'b0;
    queuePixel   = 1'b0;
    queueDequeue = 1'b0;
    indexValid   = 1'b0;
    indexOut     = '0;
    done         = 1'b0;
    underrun     = 1'b0;
    load_inc_s   = 1'b0;
    accept_s     = 1'b0;
    if (abort) begin
      next_state_s = ST_IDLE;
      queueReset   = (state_r != ST_IDLE);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) next_state_s = ST_CLEAR;
          else       next_state_s = ST_IDLE;
        end
        ST_CLEAR: begin
          queueReset   = 1'b1;
          next_state_s = ST_LOAD;
        end
        ST_LOAD: begin
          pixelReady = 1'b1;
          if (pixelValid) begin
            queuePixel = pixelIn;
            load_inc_s = 1'b1;
            if (load_count_r == LAST_PIXEL) next_state_s = ST_WAIT_FIN;
            else                            next_state_s = ST_LOAD;
          end else if (load_count_r == '0) begin
            // Nothing captured yet: keep the queue clear so its sample
            // position stays aligned with the first real pixel.
            queueReset   = 1'b1;
            next_state_s = ST_LOAD;
          end else begin
            // A gap mid-image would desynchronise the queue; drop the image.
            underrun     = 1'b1;
            queueReset   = 1'b1;
            next_state_s = ST_IDLE;
          end
        end
        ST_WAIT_FIN: begin
          if (queueFinished) next_state_s = ST_DRAIN;
          else               next_state_s = ST_WAIT_FIN;
        end
        ST_DRAIN: begin
          if (queueEmpty) begin
            next_state_s = ST_DONE;
          end else begin
            indexValid = 1'b1;
            indexOut   = queueIndex;
            if (indexReady) begin
              queueDequeue = 1'b1;
              accept_s     = 1'b1;
              next_state_s = ST_GAP;
            end else begin
              next_state_s = ST_DRAIN;
            end
          end
        end
        ST_GAP: begin
          // Bubble so the queue head reflects the dequeue before re-offering.
          next_state_s = ST_DRAIN;
        end
        ST_DONE: begin
          done         = 1'b1;
          next_state_s = ST_IDLE;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and pixel load counter (cleared whenever not loading).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      load_count_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (load_inc_s)                          load_count_r <= load_count_r + 1'b1;
      else if (abort || state_r != ST_LOAD)    load_count_r <= '0;
      else                                     load_count_r <= load_count_r;
    end
  end

`ifdef INPUT_SEQ_COUNT_EN
  // Accepted-index counter: cleared when a new image begins, held after it ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      activeCount <= '0;
    end else if (state_r == ST_CLEAR) begin
      activeCount <= '0;
    end else if (accept_s) begin
      activeCount <= activeCount + 1'b1;
    end else begin
      activeCount <= activeCount;
    end
  end
`endif

endmodule

// File: tb/tb_input_queue_sequencer.sv
// Directed bench for input_queue_sequencer with a small behavioural pixel
// queue attached. Optional build macro INPUT_SEQ_COUNT_EN also checks activeCount.
module tb_input_queue_sequencer;

  localparam int N = 10;
  localparam int W = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic         abort;
  logic         pixelValid;
  logic         pixelIn;
  logic         pixelReady;
  logic         queueReset;
  logic         queuePixel;
  logic         queueDequeue;
  logic [W-1:0] queueIndex;
  logic         queueEmpty;
  logic         queueFinished;
  logic         indexValid;
  logic [W-1:0] indexOut;
  logic         indexReady;
  logic         busy;
  logic         done;
  logic         underrun;
`ifdef INPUT_SEQ_COUNT_EN
  logic [W:0]   activeCount;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_idx [0:15];
  int           exp_n;

  input_queue_sequencer #(.INPUT_LAYER_NODES(N), .INDEX_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pixelValid(pixelValid), .pixelIn(pixelIn), .pixelReady(pixelReady),
    .queueReset(queueReset), .queuePixel(queuePixel), .queueDequeue(queueDequeue),
    .queueIndex(queueIndex), .queueEmpty(queueEmpty), .queueFinished(queueFinished),
    .indexValid(indexValid), .indexOut(indexOut), .indexReady(indexReady),
    .busy(busy), .done(done),
`ifdef INPUT_SEQ_COUNT_EN
    .activeCount(activeCount),
`endif
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural queue: samples queuePixel every clock until N samples taken,
  // storing the positions of ones; pops the head on queueDequeue.
  logic [W-1:0] qmem [0:15];
  logic [4:0]   qhead, qtail, qpos;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qhead <= 5'd0; qtail <= 5'd0; qpos <= 5'd0;
    end else if (queueReset) begin
      qhead <= 5'd0; qtail <= 5'd0; qpos <= 5'd0;
    end else begin
      if (queueDequeue && qhead != qtail) qhead <= qhead + 5'd1;
      if (qpos < 5'd10) begin
        if (queuePixel) begin
          qmem[qtail[3:0]] <= W'(qpos);
          qtail <= qtail + 5'd1;
        end
        qpos <= qpos + 5'd1;
      end
    end
  end

  assign queueIndex    = qmem[qhead[3:0]];
  assign queueEmpty    = (qhead == qtail);
  assign queueFinished = (qpos == 5'd10);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [W-1:0] bits);
    exp_n = 0;
    for (int i = 0; i < 16; i++) exp_idx[i] = 10'h3FF;
    for (int i = 0; i < N; i++) begin
      if (bits[i]) begin
        exp_idx[exp_n] = W'(i);
        exp_n++;
      end
    end
  endtask

  // Start an image and stream all N pixels contiguously; ends in WAIT_FIN.
  task automatic load_image(input logic [W-1:0] bits, input bit gap_first);
    nc(); start = 1'b1; #1;
    check("idle_busy", busy, 0);
    nc(); start = 1'b0; #1;
    check("clear_qreset", queueReset, 1);
    check("clear_busy", busy, 1);
    if (gap_first) begin
      nc(); pixelValid = 1'b0; #1;
      check("gap_first_qreset", queueReset, 1);
      check("gap_first_underrun", underrun, 0);
      check("gap_first_ready", pixelReady, 1);
    end
    for (int i = 0; i < N; i++) begin
      nc(); pixelValid = 1'b1; pixelIn = bits[i]; #1;
      check("load_ready", pixelReady, 1);
      check("load_pixel", queuePixel, bits[i]);
    end
    nc(); pixelValid = 1'b0; pixelIn = 1'b0; #1;
    check("waitfin_ready", pixelReady, 0);
    check("waitfin_busy", busy, 1);
  endtask

  // Drain from the first DRAIN cycle; ready_mode 0 = always ready, 1 = pattern.
  task automatic drain(input bit ready_mode, input int exp_done_c);
    int k = 0;
    int done_c = -1;
    bit prev_hs = 1'b0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_idx = '0;
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      nc(); indexReady = ready_mode ? (c % 3 != 1) : 1'b1; #1;
      if (prev_hs) check("gap_valid_low", indexValid, 0);
      if (prev_stall) begin
        check("stall_valid_held", indexValid, 1);
        check("stall_index_held", indexOut, prev_idx);
      end
      prev_hs    = indexValid && indexReady;
      prev_stall = indexValid && !indexReady;
      prev_idx   = indexOut;
      if (indexValid && indexReady) begin
        check("index_value", indexOut, (k < 16) ? exp_idx[k] : 10'h3FF);
        check("dequeue_pulse", queueDequeue, 1);
        k++;
      end
      if (done) done_c = c;
    end
    check("index_count", k, exp_n);
    check("done_cycle", done_c, exp_done_c);
    nc(); indexReady = 1'b0; #1;
    check("busy_after_done", busy, 0);
    check("done_single", done, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pixelValid = 1'b0; pixelIn = 1'b0; indexReady = 1'b0;

    // Reset state
    nc();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_qreset", queueReset, 0);
    check("rst_ivalid", indexValid, 0);
    check("rst_ready", pixelReady, 0);
    reset = 1'b1;

    // Image 1: pixels 0,0,1,0,1,1,0,1,0,1 -> indices 2,4,5,7,9
    set_exp(10'b1010110100);
    load_image(10'b1010110100, 1'b0);
    drain(1'b0, 11);
`ifdef INPUT_SEQ_COUNT_EN
    check("active_count", activeCount, 5);
`endif

    // Image 2 with a first-cycle gap and stalling downstream -> 0,1,3,4,6,7
    set_exp(10'b0011011011);
    load_image(10'b0011011011, 1'b1);
    drain(1'b1, 17);

    // All-zero image: done the cycle after queueEmpty is seen in DRAIN
    set_exp(10'b0000000000);
    load_image(10'b0000000000, 1'b0);
    drain(1'b0, 1);

    // Underrun after the 4th pixel
    nc(); start = 1'b1;
    nc(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nc(); pixelValid = 1'b1; pixelIn = 1'b1;
    end
    nc(); pixelValid = 1'b0; #1;
    check("underrun_pulse", underrun, 1);
    check("underrun_qreset", queueReset, 1);
    nc(); #1;
    check("underrun_idle", busy, 0);
    check("underrun_single", underrun, 0);
    set_exp(10'b1010110100);
    load_image(10'b1010110100, 1'b0);
    drain(1'b0, 11);

    // Abort during DRAIN after two indices
    load_image(10'b1010110100, 1'b0);
    nc(); indexReady = 1'b1; #1;
    check("abort_idx0", indexOut, 2);
    nc(); #1;
    check("abort_gap0", indexValid, 0);
    nc(); #1;
    check("abort_idx1", indexOut, 4);
    nc(); #1;
    nc(); abort = 1'b1; #1;
    check("abort_qreset", queueReset, 1);
    check("abort_no_done", done, 0);
    check("abort_no_deq", queueDequeue, 0);
    nc(); abort = 1'b0; indexReady = 1'b0; #1;
    check("abort_idle", busy, 0);
    check("abort_qreset_single", queueReset, 0);
    check("abort_done_low", done, 0);

    // start together with abort: abort wins
    nc(); start = 1'b1; abort = 1'b1; #1;
    check("abort_idle_qreset", queueReset, 0);
    nc(); start = 1'b0; abort = 1'b0; #1;
    check("abort_wins", busy, 0);

    // Asynchronous reset mid-LOAD
    nc(); start = 1'b1;
    nc(); start = 1'b0;
    nc(); pixelValid = 1'b1; pixelIn = 1'b1;
    nc(); #1;
    check("midload_pixel", queuePixel, 1);
    reset = 1'b0; #1;
    check("arst_busy", busy, 0);
    check("arst_ready", pixelReady, 0);
    check("arst_pixel", queuePixel, 0);
    check("arst_qreset", queueReset, 0);
    nc(); reset = 1'b1; pixelValid = 1'b0; pixelIn = 1'b0; #1;
    check("arst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
